clk_period_meter: RTL and testbench

Synchronous period and high-time meter for divided-clock signals produced by the frequency-divider stages (divby2 and siblings). It sits directly downstream of a divider and takes the divider output `Q` as `sig_in`, in the same `clk` domain. On each `start` request it measures one full period of `sig_in` (rising edge to rising edge) and its high time, both in `clk` cycles. A timeout guards against a stuck divider output.

---
 rtl/clk_period_meter_if.sv | 33 +++
 rtl/clk_period_meter.sv | 131 +++++++++++++
 tb/tb_clk_period_meter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: request/result bundle for the period meter.
// master drives sig_in/start, slave returns status and results.
interface clk_period_meter_if #(
  parameter int CNT_W = 16
);
  logic             sig_in;
  logic             start;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;

  modport master (
    output sig_in,
    output start,
    input  busy,
    input  done,
    input  timeout,
    input  period,
    input  high_time
  );

  modport slave (
    input  sig_in,
    input  start,
    output busy,
    output done,
    output timeout,
    output period,
    output high_time
  );
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: one-shot rise-to-rise period and high-time meter
// for divider outputs, with a saturating-counter timeout.
module clk_period_meter #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  clk_period_meter_if.slave mif
);
  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    FIN
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           state_n;
  logic             s1;
  logic             s2;
  logic             rise;
  logic             at_max;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_n;
  logic [CNT_W-1:0] per;
  logic [CNT_W-1:0] per_n;
  logic [CNT_W-1:0] hi;
  logic [CNT_W-1:0] hi_n;
  logic             tout;
  logic             tout_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      hcnt  <= '0;
      per   <= '0;
      hi    <= '0;
      tout  <= 1'b0;
    end else begin
      state <= state_n;
      s1    <= mif.sig_in;
      s2    <= s1;
      cnt   <= cnt_n;
      hcnt  <= hcnt_n;
      per   <= per_n;
      hi    <= hi_n;
      tout  <= tout_n;
    end
  end

  assign rise   = s1 & ~s2;
  assign at_max = (cnt == MAX);

  // FIN is the done cycle: not IDLE yet, so a start there is dropped
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hcnt_n  = hcnt;
    per_n   = per;
    hi_n    = hi;
    tout_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mif.start) begin
          state_n = ARM;
          cnt_n   = '0;
          hcnt_n  = '0;
        end
      end
      ARM: begin
        priority case (1'b1)
          rise: begin
            state_n = MEAS;
            cnt_n   = ONE;
            hcnt_n  = ONE;
          end
          at_max: begin
            state_n = FIN;
            per_n   = '0;
            hi_n    = '0;
            tout_n  = 1'b1;
          end
          default: begin
            cnt_n = cnt + ONE;
          end
        endcase
      end
      MEAS: begin
        priority case (1'b1)
          rise: begin
            state_n = FIN;
            per_n   = cnt;
            hi_n    = hcnt;
          end
          at_max: begin
            state_n = FIN;
            per_n   = '0;
            hi_n    = '0;
            tout_n  = 1'b1;
          end
          default: begin
            cnt_n = cnt + ONE;
            if (s1) begin
              hcnt_n = hcnt + ONE;
            end
          end
        endcase
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign mif.busy      = (state == ARM) | (state == MEAS);
  assign mif.done      = (state == FIN);
  assign mif.timeout   = tout;
  assign mif.period    = per;
  assign mif.high_time = hi;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: scoreboard bench for clk_period_meter.
// Stimulus pushes expected results; negedge monitors pop and compare.
module tb_clk_period_meter;
  typedef struct {
    logic [15:0] p;
    logic [15:0] h;
    logic        t;
  } exp_t;

  logic clk;
  logic rst;
  int   pass_n;
  int   total_n;
  exp_t q16[$];
  exp_t q4[$];

  int   mode;
  logic lvl;
  int   hi_len;
  int   lo_len;
  int   ph;

  clk_period_meter_if #(.CNT_W(16)) m16 ();
  clk_period_meter_if #(.CNT_W(4))  m4 ();

  clk_period_meter #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .mif (m16.slave)
  );

  clk_period_meter #(.CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .mif (m4.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      pass_n++;
    end
  endtask

  // mode 0: hold lvl; mode 1: periodic hi_len high / lo_len low
  initial begin
    m16.sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) begin
        m16.sig_in = lvl;
      end else begin
        m16.sig_in = (ph < hi_len);
        ph = (ph + 1) % (hi_len + lo_len);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m16.done) begin
      if (q16.size() == 0) begin
        chk("spurious_done16", 1, 0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("period16", 32'(m16.period), 32'(e.p));
        chk("high16", 32'(m16.high_time), 32'(e.h));
        chk("timeout16", 32'(m16.timeout), 32'(e.t));
        chk("busy_at_done16", 32'(m16.busy), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m4.done) begin
      if (q4.size() == 0) begin
        chk("spurious_done4", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("period4", 32'(m4.period), 32'(e.p));
        chk("high4", 32'(m4.high_time), 32'(e.h));
        chk("timeout4", 32'(m4.timeout), 32'(e.t));
      end
    end
  end

  task automatic push16(int p, int h, logic t);
    exp_t e;
    e.p = 16'(p);
    e.h = 16'(h);
    e.t = t;
    q16.push_back(e);
  endtask

  task automatic start16();
    @(posedge clk);
    #1 m16.start = 1'b1;
    @(posedge clk);
    #1 m16.start = 1'b0;
  endtask

  task automatic wait_done16(string nm, int lim);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (m16.done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      chk({nm, "_done_bound"}, 0, 1);
    end
  endtask

  task automatic set_pat(int h, int l, int p0);
    @(negedge clk);
    hi_len = h;
    lo_len = l;
    ph     = p0;
    mode   = 1;
  endtask

  initial begin
    int k;
    int nd;
    pass_n    = 0;
    total_n   = 0;
    mode      = 1;
    lvl       = 1'b0;
    hi_len    = 1;
    lo_len    = 1;
    ph        = 0;
    rst       = 1'b1;
    m16.start = 1'b0;
    m4.start  = 1'b0;
    m4.sig_in = 1'b0;

    #22;
    chk("rst_busy", 32'(m16.busy), 0);
    chk("rst_done", 32'(m16.done), 0);
    chk("rst_timeout", 32'(m16.timeout), 0);
    chk("rst_period", 32'(m16.period), 0);
    chk("rst_high", 32'(m16.high_time), 0);
    chk("rst_busy4", 32'(m4.busy), 0);
    #28 rst = 1'b0;

    // divby2 source
    push16(2, 1, 1'b0);
    start16();
    @(negedge clk);
    chk("busy_after_start", 32'(m16.busy), 1);
    wait_done16("div2", 20);

    // 3 high / 5 low, then 1 high / 6 low
    set_pat(3, 5, 0);
    push16(8, 3, 1'b0);
    start16();
    wait_done16("p3_5", 40);

    set_pat(1, 6, 0);
    push16(7, 1, 1'b0);
    start16();
    wait_done16("p1_6", 40);

    // CNT_W=4 timeout with input stuck low
    begin
      exp_t e;
      e.p = '0;
      e.h = '0;
      e.t = 1'b1;
      q4.push_back(e);
    end
    @(posedge clk);
    #1 m4.start = 1'b1;
    @(posedge clk);
    #1 m4.start = 1'b0;
    @(negedge clk);
    chk("busy4_rise", 32'(m4.busy), 1);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      if (m4.done) break;
    end
    chk("timeout4_cycles", 32'(k), 16);
    chk("busy4_at_done", 32'(m4.busy), 0);

    // restart attempts mid-measurement and in the done cycle
    set_pat(3, 5, 0);
    push16(8, 3, 1'b0);
    start16();
    repeat (3) @(posedge clk);
    #1 m16.start = 1'b1;
    @(posedge clk);
    #1 m16.start = 1'b0;
    wait_done16("restart", 40);
    m16.start = 1'b1;
    @(posedge clk);
    #1 m16.start = 1'b0;
    @(negedge clk);
    chk("no_restart_busy", 32'(m16.busy), 0);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m16.done) nd++;
    end
    chk("no_second_done", 32'(nd), 0);

    // async reset in the middle of a measurement
    start16();
    repeat (8) @(negedge clk);
    chk("busy_before_rst", 32'(m16.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(m16.busy), 0);
    chk("rst_mid_done", 32'(m16.done), 0);
    chk("rst_mid_period", 32'(m16.period), 0);
    chk("rst_mid_high", 32'(m16.high_time), 0);
    @(negedge clk);
    rst = 1'b0;
    set_pat(1, 1, 0);
    push16(2, 1, 1'b0);
    start16();
    wait_done16("post_rst", 20);

    // input high at start: first edge ignored
    @(negedge clk);
    lvl  = 1'b1;
    mode = 0;
    repeat (3) @(posedge clk);
    push16(8, 4, 1'b0);
    start16();
    set_pat(4, 4, 4);
    wait_done16("high_at_start", 40);

    repeat (5) @(negedge clk);
    chk("q16_drained", 32'(q16.size()), 0);
    chk("q4_drained", 32'(q4.size()), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
